// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - command handshake between counter_ctrl and the counter datapath
interface counter_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [9:0] data;

    modport master (
        output cmd_valid,
        output cmd,
        output data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  data,
        output cmd_ready
    );
endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - key synchroniser/debouncer and command issuer for the lab counter
module counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 1000
) (
    input  logic          clk100_i,
    input  logic          rstn_i,
    input  logic [2:0]    key_i,
    input  logic [9:0]    sw_i,
    counter_ctrl_if.master cmd_if,
    output logic          drop_o,
    output logic          state_o
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int RP_W = $clog2(REPEAT_CYCLES);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;
    localparam logic [1:0] CMD_INC   = 2'b11;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    logic [2:0]      sync1, sync2;
    logic [2:0]      level, level_q;
    logic [DB_W-1:0] db_cnt [3];
    logic [RP_W-1:0] rep_cnt;
    logic [2:0]      press;
    logic            rep_hit;
    logic            ev_clr, ev_load, ev_inc, any_ev, multi_ev;
    logic [1:0]      sel_cmd;
    state_t          state, state_nx;
    logic            cmd_wr;
    logic [1:0]      cmd_q;
    logic [9:0]      data_q;

    // Two-flop synchroniser; idle (released) keys read as 1
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_i;
            sync2 <= sync1;
        end
    end

    // Debounce: level flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            level <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= ~level[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Previous debounced level, used to detect the press edge
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) level_q <= '1;
        else         level_q <= level;
    end

    assign press = level_q & ~level;

    // Auto-repeat: held at 0 while INC is released, so the press cycle is count 0
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i)                                  rep_cnt <= '0;
        else if (level[2])                            rep_cnt <= '0;
        else if (rep_cnt == RP_W'(REPEAT_CYCLES - 1)) rep_cnt <= '0;
        else                                          rep_cnt <= rep_cnt + 1'b1;
    end

    assign rep_hit  = ~level[2] && (rep_cnt == RP_W'(REPEAT_CYCLES - 1));
    assign ev_clr   = press[0];
    assign ev_load  = press[1];
    assign ev_inc   = press[2] | rep_hit;
    assign any_ev   = ev_clr | ev_load | ev_inc;
    assign multi_ev = (ev_clr & ev_load) | (ev_clr & ev_inc) | (ev_load & ev_inc);
    assign sel_cmd  = ev_clr ? CMD_CLEAR : (ev_load ? CMD_LOAD : CMD_INC);

    // FSM state register
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nx;
    end

    // FSM next state: stay in ISSUE until a transfer with no replacement command
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_ev) state_nx = ISSUE;
            ISSUE:   if (cmd_if.cmd_ready && !any_ev) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: command register write strobe and discard pulse
    always_comb begin
        cmd_wr = 1'b0;
        drop_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_wr = any_ev;
                drop_o = multi_ev;
            end
            ISSUE: begin
                if (cmd_if.cmd_ready) begin
                    cmd_wr = 1'b1;
                    drop_o = multi_ev;
                end else begin
                    drop_o = any_ev;
                end
            end
            default: ;
        endcase
    end

    // Command/operand registers; a write with no event retires the command to NOP
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_q  <= CMD_NOP;
            data_q <= '0;
        end else if (cmd_wr) begin
            cmd_q <= any_ev ? sel_cmd : CMD_NOP;
            if (any_ev && sel_cmd == CMD_LOAD) data_q <= sw_i;
        end
    end

    assign cmd_if.cmd_valid = (state == ISSUE);
    assign cmd_if.cmd       = cmd_q;
    assign cmd_if.data      = data_q;
    assign state_o          = (state == ISSUE);
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command controller for the lab counter datapath. It synchronises and debounces the three active-low board keys and turns key presses into single commands: CLEAR, LOAD of the switch value, or INC. Holding the INC key produces auto-repeat INC commands. Commands reach the counter datapath over a valid/ready handshake, and the block sits between the board pins and the counter core.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised key level must differ from the debounced level before the debounced level flips (≥2).
- REPEAT_CYCLES, 1000: period in cycles of auto-repeat INC while key_i[2] is held (≥2).
- clk100_i  in  1  system clock; all logic is on its rising edge.
- rstn_i  in  1  reset, asynchronous and active-low.
- key_i  in  3  raw board keys, active-low. Bit 0 = CLEAR, bit 1 = LOAD, bit 2 = INC.
- sw_i  in  10  board switches, sampled as the LOAD operand.
- cmd_valid_o  out  1  command pending.
- cmd_ready_i  in  1  datapath accepts the command when both valid and ready are high at a rising edge.
- cmd_o  out  2  00 NOP, 01 CLEAR, 10 LOAD, 11 INC.
- data_o  out  10  LOAD operand.
- drop_o  out  1  one-cycle pulse when a key event is discarded.
- state_o  out  1  0 = IDLE, 1 = ISSUE (for ledr_o debug).

## Operation
- Sync: each key passes through a 2-FF synchroniser. Both flops reset to 1.
- Debounce, per key:
  - The debounced level resets to 1 (released).
  - The counter increments while the synchronised value differs from the debounced level, and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
  - Release uses the same rule.
- Press event: a registered debounced level 1→0 transition, one cycle wide.
- Auto-repeat:
  - The repeat counter clears on the INC press event and whenever the debounced key_i[2] is high.
  - Otherwise it increments each cycle.
  - When it reaches REPEAT_CYCLES-1, it raises an INC event that cycle and wraps to 0.
- Priority for simultaneous events in one cycle: CLEAR > LOAD > INC. Losing events are discarded and drop_o pulses once.
- FSM IDLE:
  - An event latches cmd_o, moves to ISSUE and sets cmd_valid_o.
  - For LOAD, data_o ← sw_i in the same cycle. For other commands data_o holds.
- FSM ISSUE:
  - cmd_o, data_o and cmd_valid_o stay stable until transfer.
  - On transfer with no new event: go to IDLE and set cmd_valid_o=0, cmd_o=00.
  - On transfer with a coincident event: latch the new command, stay in ISSUE and keep valid high, giving back-to-back commands.
  - An event without transfer is discarded and drop_o pulses.
- Reset values: cmd_valid_o=0, cmd_o=00, data_o=0, drop_o=0, state_o=0. All counters are 0.
- Reset mid-operation clears a pending command immediately with no transfer.
- A key held low through reset release is treated as a new press after debounce.

## Timing
- Edge 0 is the first rising edge at which key_i is sampled low, with key_i stable afterwards.
  - Edge 1: synchroniser output low.
  - Edge DEBOUNCE_CYCLES+1: debounced level low.
  - Edge DEBOUNCE_CYCLES+2: cmd_valid_o, cmd_o and data_o valid.
  - The press-to-valid latency is therefore DEBOUNCE_CYCLES+2 cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles at the synchroniser output produces no event.
- The first auto-repeat INC is raised REPEAT_CYCLES-1 cycles after the press event. Later ones follow every REPEAT_CYCLES cycles.
- Transfer takes one cycle. With cmd_ready_i tied high, cmd_valid_o is high for exactly one cycle per isolated command.
- drop_o is high in the cycle the discard decision is made, i.e. the event cycle. It is not registered further.
- cmd_valid_o never deasserts without a transfer, except on reset.

## Test plan
Use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8 for all scenarios.
- LOAD: sw_i=10'h2A5, cmd_ready_i=1, key_i[1] low for 20 cycles. Expect cmd_valid_o high only at edge 6 → edge 7, cmd_o=10, data_o=10'h2A5, no drop_o.
- Glitch rejection: key_i[0] low for 3 cycles then high. Expect no cmd_valid_o and no drop_o. Then low for 10 cycles → one CLEAR (cmd_o=01).
- Stall and drop: cmd_ready_i=0, press INC, then press LOAD while valid. Expect cmd_o=11 held stable and one drop_o pulse. After ready=1, one INC transfer, then IDLE with cmd_o=00.
- Simultaneous press: all three keys fall at the same edge. Expect CLEAR issued, a single drop_o pulse in the same event cycle, and no LOAD/INC command.
- Auto-repeat: cmd_ready_i=1, key_i[2] held 40 cycles. Expect INC at edge 6, then at edges 13, 21, 29, 37. No INC after release is debounced.
- Reset mid-command: cmd_ready_i=0, INC pending, pulse rstn_i low. Expect cmd_valid_o=0 asynchronously and all outputs at reset values. With key_i[2] still low, a new INC is valid 6 edges after reset release.
